// File: rtl/fifo_chain_pkg.sv
// rtl/fifo_chain_pkg.sv - shared state encoding, default sizes and PRBS-31 taps for the FIFO chain tester
package fifo_chain_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int DEF_N      = 32;
    localparam int DEF_K      = 48;
    localparam int PRBS_LEN   = 31;
    localparam int PRBS_TAP_A = 30;  // x^31 term
    localparam int PRBS_TAP_B = 27;  // x^28 term

    function automatic logic prbs_fb(input logic [PRBS_LEN-1:0] s);
        return s[PRBS_TAP_A] ^ s[PRBS_TAP_B];
    endfunction

endpackage

// File: rtl/fifo_chain_prbs.sv
// rtl/fifo_chain_prbs.sv - parallel N-bit PRBS-31 generator with seed load and advance enable
module fifo_chain_prbs
    import fifo_chain_pkg::*;
#(
    parameter int N = DEF_N
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_load,
    input  logic         i_adv,
    input  logic [N-1:0] i_seed,
    output logic [N-1:0] o_word
);

    logic [PRBS_LEN-1:0] r_state;
    logic [PRBS_LEN-1:0] w_next;
    logic [PRBS_LEN-1:0] w_seed;

    // An all-zero register would lock the LFSR, so a zero seed becomes 1
    assign w_seed = (i_seed[PRBS_LEN-1:0] == '0) ? PRBS_LEN'(1) : i_seed[PRBS_LEN-1:0];

    if (N > PRBS_LEN) begin : g_seed_hi
        logic w_unused_seed_hi;
        assign w_unused_seed_hi = ^i_seed[N-1:PRBS_LEN];
    end

    // The first bit shifted out lands in the word MSB
    always_comb begin
        w_next = r_state;
        o_word = '0;
        for (int i = N - 1; i >= 0; i--) begin
            o_word[i] = prbs_fb(w_next);
            w_next    = {w_next[PRBS_LEN-2:0], o_word[i]};
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= PRBS_LEN'(1);
        end else if (i_load) begin
            r_state <= w_seed;
        end else if (i_adv) begin
            r_state <= w_next;
        end
    end

endmodule

// File: rtl/fifo_chain_test_ctrl.sv
// rtl/fifo_chain_test_ctrl.sv - PRBS stream/check sequencer for the ECC FIFO chain
// Optional watchdog abort: FIFO_CHAIN_TIMEOUT_EN
module fifo_chain_test_ctrl
    import fifo_chain_pkg::*;
#(
    parameter int N       = DEF_N,
    parameter int K       = DEF_K,
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 65535
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             stop_i,
    input  logic [CNT_W-1:0] len_i,
    input  logic [N-1:0]     seed_i,
    input  logic [CNT_W-1:0] inj_idx_i,
    input  logic [K-1:0]     inj_sb_mask_i,
    input  logic [K-1:0]     inj_db_mask_i,
    output logic [N-1:0]     fifo_data_o,
    output logic             fifo_wr_o,
    input  logic             fifo_almst_full_i,
    input  logic [N-1:0]     fifo_data_i,
    output logic             fifo_rd_o,
    input  logic             fifo_empty_i,
    output logic [K-1:0]     injectsbiterr_o,
    output logic [K-1:0]     injectdbiterr_o,
    input  logic [K-1:0]     sbiterr_i,
    input  logic [K-1:0]     dbiterr_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             timeout_o,
    output logic [CNT_W-1:0] wr_cnt_o,
    output logic [CNT_W-1:0] rd_cnt_o,
    output logic [CNT_W-1:0] mismatch_cnt_o,
    output logic [CNT_W-1:0] sbit_cnt_o,
    output logic [CNT_W-1:0] dbit_cnt_o,
    output logic [K-1:0]     sbit_stage_o,
    output logic [K-1:0]     dbit_stage_o,
    output logic [N-1:0]     first_err_data_o
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_ONE;
    endfunction

    state_t           r_state;
    logic [CNT_W-1:0] r_len, r_inj_idx;
    logic [CNT_W-1:0] r_wr_cnt, r_rd_cnt, r_mis_cnt, r_sbit_cnt, r_dbit_cnt;
    logic [K-1:0]     r_sb_mask, r_db_mask, r_inj_sb, r_inj_db;
    logic [K-1:0]     r_sbit_stage, r_dbit_stage;
    logic [N-1:0]     r_fifo_data, r_first_err;
    logic             r_fifo_wr, r_rd_vld, r_timeout;

    logic             w_active, w_start, w_wr, w_rd, w_wdog_fire;
    logic [N-1:0]     w_wr_word, w_exp_word;

    assign w_active = (r_state == ST_RUN) || (r_state == ST_FLUSH);
    assign w_start  = start_i && !stop_i && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_rd     = w_active && !fifo_empty_i;
    // A stop pulse suppresses the write in the same cycle so the count freezes where stop was seen
    assign w_wr     = (r_state == ST_RUN) && !stop_i && !fifo_almst_full_i
                      && (r_wr_cnt < r_len) && !w_wdog_fire;

    fifo_chain_prbs #(.N(N)) u_wr_prbs (
        .i_clk  (clk_i),
        .i_rst  (rst_i),
        .i_load (w_start),
        .i_adv  (w_wr),
        .i_seed (seed_i),
        .o_word (w_wr_word)
    );

    fifo_chain_prbs #(.N(N)) u_chk_prbs (
        .i_clk  (clk_i),
        .i_rst  (rst_i),
        .i_load (w_start),
        .i_adv  (r_rd_vld),
        .i_seed (seed_i),
        .o_word (w_exp_word)
    );

`ifdef FIFO_CHAIN_TIMEOUT_EN
    logic [CNT_W-1:0] r_wdog;

    assign w_wdog_fire = w_active && !r_rd_vld && (r_wdog >= CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i || w_start || !w_active || r_rd_vld) begin
            r_wdog <= '0;
        end else begin
            r_wdog <= sat_inc(r_wdog);
        end
    end
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT == 0);
    assign w_wdog_fire      = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state      <= ST_IDLE;
            r_len        <= '0;
            r_inj_idx    <= '0;
            r_sb_mask    <= '0;
            r_db_mask    <= '0;
            r_wr_cnt     <= '0;
            r_rd_cnt     <= '0;
            r_mis_cnt    <= '0;
            r_sbit_cnt   <= '0;
            r_dbit_cnt   <= '0;
            r_sbit_stage <= '0;
            r_dbit_stage <= '0;
            r_first_err  <= '0;
            r_fifo_data  <= '0;
            r_fifo_wr    <= 1'b0;
            r_inj_sb     <= '0;
            r_inj_db     <= '0;
            r_rd_vld     <= 1'b0;
            r_timeout    <= 1'b0;
        end else begin
            r_fifo_wr <= w_wr;
            r_rd_vld  <= w_rd;
            r_inj_sb  <= '0;
            r_inj_db  <= '0;
            if (w_wr) begin
                r_fifo_data <= w_wr_word;
                if (r_wr_cnt == r_inj_idx) begin
                    r_inj_sb <= r_sb_mask;
                    r_inj_db <= r_db_mask;
                end
            end

            if (w_start) begin
                r_state      <= ST_RUN;
                r_len        <= len_i;
                r_inj_idx    <= inj_idx_i;
                r_sb_mask    <= inj_sb_mask_i;
                r_db_mask    <= inj_db_mask_i;
                r_wr_cnt     <= '0;
                r_rd_cnt     <= '0;
                r_mis_cnt    <= '0;
                r_sbit_cnt   <= '0;
                r_dbit_cnt   <= '0;
                r_sbit_stage <= '0;
                r_dbit_stage <= '0;
                r_first_err  <= '0;
                r_timeout    <= 1'b0;
            end else begin
                if (w_wr) begin
                    r_wr_cnt <= sat_inc(r_wr_cnt);
                end
                if (r_rd_vld) begin
                    r_rd_cnt <= sat_inc(r_rd_cnt);
                    if (fifo_data_i != w_exp_word) begin
                        r_mis_cnt <= sat_inc(r_mis_cnt);
                        if (r_mis_cnt == '0) begin
                            r_first_err <= fifo_data_i;
                        end
                    end
                end
                if (w_active) begin
                    if (|sbiterr_i) r_sbit_cnt <= sat_inc(r_sbit_cnt);
                    if (|dbiterr_i) r_dbit_cnt <= sat_inc(r_dbit_cnt);
                    r_sbit_stage <= r_sbit_stage | sbiterr_i;
                    r_dbit_stage <= r_dbit_stage | dbiterr_i;
                end

                case (r_state)
                    ST_RUN: begin
                        if (stop_i || (r_wr_cnt == r_len)) r_state <= ST_FLUSH;
                    end
                    ST_FLUSH: begin
                        if ((r_rd_cnt == r_wr_cnt) && !r_rd_vld && !w_rd) r_state <= ST_DONE;
                    end
                    default: ;
                endcase

                if (w_wdog_fire) begin
                    r_state   <= ST_DONE;
                    r_timeout <= 1'b1;
                end
            end
        end
    end

    assign fifo_data_o      = r_fifo_data;
    assign fifo_wr_o        = r_fifo_wr;
    assign fifo_rd_o        = w_rd;
    assign injectsbiterr_o  = r_inj_sb;
    assign injectdbiterr_o  = r_inj_db;
    assign busy_o           = w_active;
    assign done_o           = (r_state == ST_DONE);
    assign timeout_o        = r_timeout;
    assign wr_cnt_o         = r_wr_cnt;
    assign rd_cnt_o         = r_rd_cnt;
    assign mismatch_cnt_o   = r_mis_cnt;
    assign sbit_cnt_o       = r_sbit_cnt;
    assign dbit_cnt_o       = r_dbit_cnt;
    assign sbit_stage_o     = r_sbit_stage;
    assign dbit_stage_o     = r_dbit_stage;
    assign first_err_data_o = r_first_err;

endmodule

// File: tb/tb_fifo_chain_test_ctrl.sv
// tb/tb_fifo_chain_test_ctrl.sv - self-checking bench for fifo_chain_test_ctrl with a queue-based chain model
module tb_fifo_chain_test_ctrl;

    localparam int N    = 32;
    localparam int K    = 48;
    localparam int CW   = 32;
    localparam int TMO  = 100;
    localparam int MAXW = 256;
    localparam logic [N-1:0] DB_FLIP = 32'h0000_0003;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_i = 1'b1;
    logic          start_i = 1'b0, stop_i = 1'b0;
    logic [CW-1:0] len_i = '0, inj_idx_i = '0;
    logic [N-1:0]  seed_i = '0;
    logic [K-1:0]  inj_sb_mask_i = '0, inj_db_mask_i = '0;
    logic [N-1:0]  fifo_data_o, fifo_data_i;
    logic          fifo_wr_o, fifo_rd_o, fifo_almst_full_i, fifo_empty_i;
    logic [K-1:0]  injectsbiterr_o, injectdbiterr_o, sbiterr_i, dbiterr_i;
    logic          busy_o, done_o, timeout_o;
    logic [CW-1:0] wr_cnt_o, rd_cnt_o, mismatch_cnt_o, sbit_cnt_o, dbit_cnt_o;
    logic [K-1:0]  sbit_stage_o, dbit_stage_o;
    logic [N-1:0]  first_err_data_o;

    fifo_chain_test_ctrl #(.N(N), .K(K), .CNT_W(CW), .TIMEOUT(TMO)) dut (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .stop_i(stop_i),
        .len_i(len_i), .seed_i(seed_i), .inj_idx_i(inj_idx_i),
        .inj_sb_mask_i(inj_sb_mask_i), .inj_db_mask_i(inj_db_mask_i),
        .fifo_data_o(fifo_data_o), .fifo_wr_o(fifo_wr_o), .fifo_almst_full_i(fifo_almst_full_i),
        .fifo_data_i(fifo_data_i), .fifo_rd_o(fifo_rd_o), .fifo_empty_i(fifo_empty_i),
        .injectsbiterr_o(injectsbiterr_o), .injectdbiterr_o(injectdbiterr_o),
        .sbiterr_i(sbiterr_i), .dbiterr_i(dbiterr_i),
        .busy_o(busy_o), .done_o(done_o), .timeout_o(timeout_o),
        .wr_cnt_o(wr_cnt_o), .rd_cnt_o(rd_cnt_o), .mismatch_cnt_o(mismatch_cnt_o),
        .sbit_cnt_o(sbit_cnt_o), .dbit_cnt_o(dbit_cnt_o),
        .sbit_stage_o(sbit_stage_o), .dbit_stage_o(dbit_stage_o),
        .first_err_data_o(first_err_data_o)
    );

    int n_cmp = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    // Reference PRBS: bit recurrence b[t] = b[t-31] ^ b[t-28], words packed MSB-first
    bit           hist [0:31+MAXW*N-1];
    logic [N-1:0] exp_w [0:MAXW-1];

    task automatic gen_words(input logic [N-1:0] seed);
        logic [30:0] s;
        s = seed[30:0];
        if (s == 31'd0) s = 31'd1;
        for (int k = 0; k < 31; k++) hist[k] = s[30-k];
        for (int k = 31; k < 31 + MAXW*N; k++) hist[k] = hist[k-31] ^ hist[k-28];
        for (int w = 0; w < MAXW; w++)
            for (int j = 0; j < N; j++) exp_w[w][N-1-j] = hist[31 + w*N + j];
    endtask

    // Chain model: ideal FIFO, 1-cycle read latency, DBIT corrupts data, SBIT only flags
    typedef struct { logic [N-1:0] d; logic [K-1:0] sb; logic [K-1:0] db; } word_t;
    word_t        q[$];
    word_t        pe;
    int           q_cnt = 0;
    int           widx = 0;
    int           m_inj = 0;
    logic [K-1:0] m_sb = '0, m_db = '0;
    bit           force_empty = 1'b0, bp_force = 1'b0;

    assign fifo_empty_i      = (q_cnt == 0) || force_empty;
    assign fifo_almst_full_i = (q_cnt >= 6) || bp_force;

    always @(posedge clk) begin
        if (rst_i) begin
            q.delete();
            q_cnt       <= 0;
            fifo_data_i <= '0;
            sbiterr_i   <= '0;
            dbiterr_i   <= '0;
            widx = 0;
        end else begin
            if (fifo_rd_o) begin
                if (q.size() == 0) begin
                    n_cmp++; n_fail++;
                    $display("FAIL rd_while_empty got=1 exp=0");
                end else begin
                    pe = q.pop_front();
                    fifo_data_i <= pe.d;
                    sbiterr_i   <= pe.sb;
                    dbiterr_i   <= pe.db;
                end
            end else begin
                sbiterr_i <= '0;
                dbiterr_i <= '0;
            end
            if (fifo_wr_o) begin
                if (widx < MAXW) begin
                    chk($sformatf("wr_data[%0d]", widx), fifo_data_o, exp_w[widx]);
                    chk($sformatf("inj_sb[%0d]", widx), injectsbiterr_o, (widx == m_inj) ? m_sb : '0);
                    chk($sformatf("inj_db[%0d]", widx), injectdbiterr_o, (widx == m_inj) ? m_db : '0);
                end
                pe.d  = fifo_data_o ^ ((injectdbiterr_o != '0) ? DB_FLIP : '0);
                pe.sb = injectsbiterr_o;
                pe.db = injectdbiterr_o;
                q.push_back(pe);
                widx = widx + 1;
            end else if ((injectsbiterr_o != '0) || (injectdbiterr_o != '0)) begin
                n_cmp++; n_fail++;
                $display("FAIL inj_without_write got=1 exp=0");
            end
            q_cnt <= q.size();
        end
    end

    typedef struct {
        logic [N-1:0] seed;
        int           len;
        int           inj;
        logic [K-1:0] sb;
        logic [K-1:0] db;
        int           stop_at;
        int           bp;
        int           e_wr;
        int           e_mis;
        int           e_sbit;
        int           e_dbit;
    } vec_t;

    vec_t tbl [8];

    task automatic start_run(input vec_t v);
        gen_words(v.seed);
        @(negedge clk);
        m_inj = v.inj; m_sb = v.sb; m_db = v.db; widx = 0;
        seed_i = v.seed; len_i = CW'(v.len); inj_idx_i = CW'(v.inj);
        inj_sb_mask_i = v.sb; inj_db_mask_i = v.db;
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    task automatic check_run(input vec_t v, input string tag);
        bit           hit;
        logic [N-1:0] fe;
        hit = (v.inj < v.e_wr);
        fe  = (v.e_mis != 0) ? (exp_w[v.inj] ^ DB_FLIP) : '0;
        chk({tag, ".done"}, done_o, 1);
        chk({tag, ".busy"}, busy_o, 0);
        chk({tag, ".timeout"}, timeout_o, 0);
        chk({tag, ".wr_cnt"}, wr_cnt_o, v.e_wr);
        chk({tag, ".rd_cnt"}, rd_cnt_o, v.e_wr);
        chk({tag, ".mismatch"}, mismatch_cnt_o, v.e_mis);
        chk({tag, ".sbit_cnt"}, sbit_cnt_o, v.e_sbit);
        chk({tag, ".dbit_cnt"}, dbit_cnt_o, v.e_dbit);
        chk({tag, ".sbit_stage"}, sbit_stage_o, hit ? v.sb : '0);
        chk({tag, ".dbit_stage"}, dbit_stage_o, hit ? v.db : '0);
        chk({tag, ".first_err"}, first_err_data_o, fe);
    endtask

    task automatic do_run(input vec_t v, input string tag);
        int cyc;
        bit stopped;
        start_run(v);
        cyc = 0;
        stopped = 1'b0;
        while (!done_o && cyc < 5000) begin
            stop_i = 1'b0;
            if (v.bp != 0) bp_force = ($urandom_range(0, 1) == 1);
            if (v.stop_at >= 0 && !stopped && busy_o && wr_cnt_o == CW'(v.stop_at)) begin
                stop_i  = 1'b1;
                stopped = 1'b1;
            end
            @(negedge clk);
            cyc++;
        end
        stop_i   = 1'b0;
        bp_force = 1'b0;
        check_run(v, tag);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".wr_cnt"}, wr_cnt_o, 0);
        chk({tag, ".rd_cnt"}, rd_cnt_o, 0);
        chk({tag, ".cnts"}, {mismatch_cnt_o, sbit_cnt_o} | {32'h0, dbit_cnt_o}, 0);
        chk({tag, ".stages"}, sbit_stage_o | dbit_stage_o, 0);
        chk({tag, ".inject"}, injectsbiterr_o | injectdbiterr_o, 0);
        chk({tag, ".data"}, {fifo_data_o, first_err_data_o}, 0);
        chk({tag, ".flags"}, {fifo_wr_o, fifo_rd_o, busy_o, done_o, timeout_o}, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_time_limit got=expired exp=finished");
        $fatal(1, "time limit");
    end

    initial begin
        vec_t v;
        int   cyc;

        //           seed           len     inj sb                 db      stop bp  wr  mis sb db
        tbl[0] = '{32'h0000_0001,   16,     0,  48'h0,             48'h0,  -1,  0,  16, 0,  0, 0};
        tbl[1] = '{32'h0123_4567,   64,     5,  48'h1,             48'h0,  -1,  0,  64, 0,  1, 0};
        tbl[2] = '{32'h0000_ACE1,   64,     10, 48'h0,             48'h1,  -1,  0,  64, 1,  0, 1};
        tbl[3] = '{32'h05A5_A5A5,   100000, 70, 48'h1,             48'h1,  50,  1,  50, 0,  0, 0};
        tbl[4] = '{32'h0000_0007,   0,      0,  48'h1,             48'h1,  -1,  0,  0,  0,  0, 0};
        tbl[5] = '{32'h7654_3210,   8,      7,  48'h8000_0000_0001, 48'h2, -1,  1,  8,  1,  1, 1};
        tbl[6] = '{32'h0BAD_F00D,   8,      8,  48'h0,             48'h1,  -1,  0,  8,  0,  0, 0};
        tbl[7] = '{32'h0000_0000,   4,      1,  48'h0,             48'h0,  -1,  0,  4,  0,  0, 0};

        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst_i = 1'b0;
        @(negedge clk);
        chk_all_zero("idle");

        for (int i = 0; i < 8; i++) do_run(tbl[i], $sformatf("tbl%0d", i));

        for (int r = 0; r < 12; r++) begin
            v.seed    = $urandom;
            v.len     = $urandom_range(0, 40);
            v.inj     = $urandom_range(0, 45);
            v.sb      = ($urandom_range(0, 2) == 0) ? 48'h0 : (48'h1 << $urandom_range(0, 47));
            v.db      = ($urandom_range(0, 2) == 0) ? 48'h0 : (48'h1 << $urandom_range(0, 47));
            v.stop_at = -1;
            v.bp      = $urandom_range(0, 1);
            v.e_wr    = v.len;
            v.e_mis   = (v.inj < v.len && v.db != '0) ? 1 : 0;
            v.e_sbit  = (v.inj < v.len && v.sb != '0) ? 1 : 0;
            v.e_dbit  = v.e_mis;
            do_run(v, $sformatf("rnd%0d", r));
        end

        v = '{32'h0135_79BD, 100000, 0, 48'h0, 48'h0, -1, 0, 0, 0, 0, 0};
        start_run(v);
        cyc = 0;
        while (wr_cnt_o < 20 && cyc < 500) begin @(negedge clk); cyc++; end
        chk("rst_mid.reach", (wr_cnt_o >= 20), 1);
        rst_i = 1'b1;
        @(negedge clk);
        chk_all_zero("rst_mid");
        rst_i = 1'b0;
        do_run(tbl[0], "after_rst");

        v = '{32'h0246_8ACE, 20, 0, 48'h0, 48'h0, -1, 0, 0, 0, 0, 0};
        start_run(v);
        cyc = 0;
        while (rd_cnt_o < 3 && cyc < 200) begin @(negedge clk); cyc++; end
        chk("tmo.reads", (rd_cnt_o >= 3), 1);
        force_empty = 1'b1;
`ifdef FIFO_CHAIN_TIMEOUT_EN
        repeat (TMO - 10) @(negedge clk);
        chk("tmo.early_busy", busy_o, 1);
        cyc = 0;
        while (!done_o && cyc < 40) begin @(negedge clk); cyc++; end
        chk("tmo.done", done_o, 1);
        chk("tmo.flag", timeout_o, 1);
        chk("tmo.busy", busy_o, 0);
`else
        repeat (3 * TMO) @(negedge clk);
        chk("stall.busy", busy_o, 1);
        chk("stall.done", done_o, 0);
        chk("stall.flag", timeout_o, 0);
`endif
        rst_i = 1'b1;
        @(negedge clk);
        rst_i = 1'b0;
        force_empty = 1'b0;
        @(negedge clk);
        chk_all_zero("final_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
